gpio_count_ctrl: RTL and testbench
==================================

GPIO_COUNT_CTRL -- requirements
Module: gpio_count_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 2: counter/output width, driven onto mprj_io[WIDTH-1:0].
REQ-002 SHALL have parameter DIV_W, default 16: prescaler divisor width.
REQ-003 SHALL have port wb_clk_i  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port wb_rst_i  input  1: synchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1: command present.
REQ-006 SHALL have port cmd_op  input  2: 00 STOP, 01 START, 10 STEP, 11 LOAD.
REQ-007 SHALL have port cmd_limit  input  WIDTH: terminal count for LOAD.
REQ-008 SHALL have port cmd_div  input  DIV_W: prescale divisor for LOAD; tick period is cmd_div+1 cycles.
REQ-009 SHALL have port cmd_oneshot  input  1: one-shot mode for LOAD.
REQ-010 SHALL have port cmd_ready  output  1: command accepted on cycles with cmd_valid && cmd_ready.
REQ-011 SHALL have port count_out  output  WIDTH: current count, registered.
REQ-012 SHALL have port io_oeb  output  WIDTH: active-low pad output enable.
REQ-013 SHALL have port busy  output  1: high in RUN or STEP.
REQ-014 SHALL have port wrap_pulse  output  1: one-cycle pulse on each wrap to 0.
REQ-015 SHALL have port wrap_count  output  8: wrap counter, saturating at 255.

Function
REQ-016 SHALL implement FSM states IDLE, RUN, STEP; busy = (state != IDLE).
REQ-017 SHALL drive cmd_ready = 1 in IDLE and RUN, 0 in STEP.
REQ-018 Prescaler SHALL count 0..div and assert an internal tick in the cycle it equals div, then return to 0; it SHALL be cleared on entering RUN or STEP and on LOAD; with div = 0, tick SHALL fire every cycle.
REQ-019 Prescaler SHALL advance only in RUN or STEP.
REQ-020 IDLE+LOAD: latch limit/div/oneshot; clear count_out, prescaler, wrap_count; remain IDLE.
REQ-021 IDLE+START -> RUN; IDLE+STEP -> STEP; IDLE+STOP accepted, no effect.
REQ-022 RUN+STOP -> IDLE next cycle, count_out held; RUN+START/STEP/LOAD SHALL be accepted and ignored.
REQ-023 On tick: count_out = (count_out == limit) ? 0 : count_out+1, updating the cycle after the tick.
REQ-024 wrap_pulse SHALL be high for exactly the one cycle in which count_out first shows 0 after a wrap; wrap_count increments in the same cycle, saturating at 255.
REQ-025 STEP SHALL perform exactly one tick-driven update, then return to IDLE in the same cycle that count_out updates.
REQ-026 RUN with oneshot = 1 SHALL return to IDLE in the cycle the wrap to 0 occurs.
REQ-027 With limit = 0, count_out SHALL stay 0 and wrap_pulse SHALL fire on every tick.
REQ-028 With limit > 2^WIDTH-1 impossible by width; limit = 2^WIDTH-1 gives natural modulo wrap.
REQ-029 io_oeb SHALL be all ones until the first accepted START or STEP, then all zeros until reset.
REQ-030 Commands with cmd_valid low SHALL have no effect; cmd_* SHALL be sampled only on an accepted cycle.

Reset
REQ-031 On wb_rst_i high at a clock edge: state IDLE, count_out 0, prescaler 0, wrap_pulse 0, wrap_count 0, limit 2^WIDTH-1, div 0, oneshot 0, io_oeb all ones.
REQ-032 Reset SHALL override any simultaneous command and abort RUN/STEP mid-operation, with no wrap_pulse generated.

Verification
REQ-033 Reset, START, div=0, limit=3 -> count_out 0,1,2,3,0 on successive cycles; wrap_pulse on the return to 0; io_oeb 2'b00 after START.
REQ-034 LOAD limit=2, div=4, oneshot=1; START -> count_out steps every 5 cycles 1,2,0; then IDLE, busy 0, wrap_count 1.
REQ-035 STEP with div=2 from count 3, limit 3 -> cmd_ready 0 for 3 cycles; count_out 0; wrap_pulse once; IDLE.
REQ-036 RUN then STOP at count 2 -> count_out holds 2 for 20 cycles; a subsequent START resumes 3,0.
REQ-037 limit=0, div=0, 300 cycles of RUN -> count_out 0 throughout; wrap_count saturates at 255.
REQ-038 Assert wb_rst_i during RUN with a simultaneous START -> next cycle IDLE, count_out 0, io_oeb 2'b11, wrap_count 0.

Source files
------------

// File: rtl/gpio_count_ctrl.sv
// Prescaled GPIO counter with STOP/START/STEP/LOAD commands; count_out updates the cycle after a prescaler tick.
// Latency: command takes effect next cycle. Backpressure: cmd_ready low only while a STEP is in flight.
module gpio_count_ctrl #(
    parameter int WIDTH = 2,
    parameter int DIV_W = 16
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_limit,
    input  logic [DIV_W-1:0] cmd_div,
    input  logic             cmd_oneshot,
    output logic             cmd_ready,
    output logic [WIDTH-1:0] count_out,
    output logic [WIDTH-1:0] io_oeb,
    output logic             busy,
    output logic             wrap_pulse,
    output logic [7:0]       wrap_count
);

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   limit_q, limit_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [DIV_W-1:0]   presc_q, presc_d;
    logic               oneshot_q, oneshot_d;
    logic               oe_q, oe_d;
    logic               wrap_pulse_q, wrap_pulse_d;
    logic [7:0]         wrap_cnt_q, wrap_cnt_d;

    logic               accept;
    logic               tick;
    logic               advance;

    assign cmd_ready  = (state_q != ST_STEP);
    assign busy       = (state_q != ST_IDLE);
    assign count_out  = count_q;
    assign io_oeb     = {WIDTH{~oe_q}};
    assign wrap_pulse = wrap_pulse_q;
    assign wrap_count = wrap_cnt_q;

    assign accept = cmd_valid && cmd_ready;
    assign tick   = busy && (presc_q == div_q);

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        limit_d      = limit_q;
        div_d        = div_q;
        presc_d      = presc_q;
        oneshot_d    = oneshot_q;
        oe_d         = oe_q;
        wrap_pulse_d = 1'b0;
        wrap_cnt_d   = wrap_cnt_q;
        advance      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    unique case (cmd_op)
                        OP_START: begin
                            state_d = ST_RUN;
                            presc_d = '0;
                            oe_d    = 1'b1;
                        end
                        OP_STEP: begin
                            state_d = ST_STEP;
                            presc_d = '0;
                            oe_d    = 1'b1;
                        end
                        OP_LOAD: begin
                            limit_d    = cmd_limit;
                            div_d      = cmd_div;
                            oneshot_d  = cmd_oneshot;
                            count_d    = '0;
                            presc_d    = '0;
                            wrap_cnt_d = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_RUN: begin
                // STOP wins over a coincident tick so the count is frozen where it was seen.
                if (accept && cmd_op == OP_STOP) begin
                    state_d = ST_IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            ST_STEP: begin
                advance = 1'b1;
                if (tick) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (advance) begin
            if (tick) begin
                presc_d = '0;
                if (count_q == limit_q) begin
                    count_d      = '0;
                    wrap_pulse_d = 1'b1;
                    if (wrap_cnt_q != 8'hFF) begin
                        wrap_cnt_d = wrap_cnt_q + 8'd1;
                    end
                    if (oneshot_q && state_q == ST_RUN) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
                end
            end else begin
                presc_d = presc_q + {{(DIV_W-1){1'b0}}, 1'b1};
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            limit_q      <= '1;
            div_q        <= '0;
            presc_q      <= '0;
            oneshot_q    <= 1'b0;
            oe_q         <= 1'b0;
            wrap_pulse_q <= 1'b0;
            wrap_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            limit_q      <= limit_d;
            div_q        <= div_d;
            presc_q      <= presc_d;
            oneshot_q    <= oneshot_d;
            oe_q         <= oe_d;
            wrap_pulse_q <= wrap_pulse_d;
            wrap_cnt_q   <= wrap_cnt_d;
        end
    end

endmodule

// File: tb/tb_gpio_count_ctrl.sv
// Scenario bench for gpio_count_ctrl: expected count/wrap values are queued as stimulus is driven
// and popped one per cycle as the DUT advances.
module tb_gpio_count_ctrl;

    localparam logic [1:0] OP_STOP  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STEP  = 2'b10;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'b00;
    logic [1:0]  cmd_limit = 2'b00;
    logic [15:0] cmd_div = 16'd0;
    logic        cmd_oneshot = 1'b0;
    logic        cmd_ready;
    logic [1:0]  count_out;
    logic [1:0]  io_oeb;
    logic        busy;
    logic        wrap_pulse;
    logic [7:0]  wrap_count;

    typedef struct {
        logic [1:0] cnt;
        logic       wrap;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    gpio_count_ctrl #(.WIDTH(2), .DIV_W(16)) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_op      (cmd_op),
        .cmd_limit   (cmd_limit),
        .cmd_div     (cmd_div),
        .cmd_oneshot (cmd_oneshot),
        .cmd_ready   (cmd_ready),
        .count_out   (count_out),
        .io_oeb      (io_oeb),
        .busy        (busy),
        .wrap_pulse  (wrap_pulse),
        .wrap_count  (wrap_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] lim,
                        input logic [15:0] dv, input logic os);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_limit   = lim;
        cmd_div     = dv;
        cmd_oneshot = os;
        cyc();
        cmd_valid   = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL reset_count got=%0d exp=0", count_out); end
        n_checks++; if (io_oeb !== 2'b11) begin n_fail++; $display("FAIL reset_oeb got=%b exp=11", io_oeb); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got=%b exp=1", cmd_ready); end
        n_checks++; if (wrap_pulse !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", wrap_pulse); end
        n_checks++; if (wrap_count !== 8'd0) begin n_fail++; $display("FAIL reset_wcnt got=%0d exp=0", wrap_count); end
    endtask

    task automatic test_invalid_cmd();
        cmd_op = OP_START;
        cmd_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cyc();
            n_checks++; if (busy !== 1'b0 || io_oeb !== 2'b11 || count_out !== 2'd0) begin
                n_fail++; $display("FAIL invalid_cmd busy=%b oeb=%b cnt=%0d exp busy=0 oeb=11 cnt=0", busy, io_oeb, count_out);
            end
        end
    endtask

    task automatic test_run_basic();
        exp_t e;
        send(OP_START, 2'd0, 16'd0, 1'b0);
        n_checks++; if (count_out !== 2'd0) begin n_fail++; $display("FAIL run_first_count got=%0d exp=0", count_out); end
        n_checks++; if (io_oeb !== 2'b00) begin n_fail++; $display("FAIL run_oeb got=%b exp=00", io_oeb); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL run_busy got=%b exp=1", busy); end
        for (int k = 1; k <= 5; k++) sb.push_back('{cnt: 2'(k % 4), wrap: (k == 4)});
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front();
            n_checks++; if (count_out !== e.cnt || wrap_pulse !== e.wrap) begin
                n_fail++; $display("FAIL run_seq cnt=%0d wrap=%b exp cnt=%0d wrap=%b", count_out, wrap_pulse, e.cnt, e.wrap);
            end
        end
        send(OP_STOP, 2'd0, 16'd0, 1'b0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL run_stop_busy got=%b exp=0", busy); end
    endtask

    task automatic test_oneshot();
        exp_t e;
        send(OP_LOAD, 2'd2, 16'd4, 1'b1);
        n_checks++; if (count_out !== 2'd0 || wrap_count !== 8'd0) begin
            n_fail++; $display("FAIL load_clear cnt=%0d wcnt=%0d exp 0 0", count_out, wrap_count);
        end
        send(OP_START, 2'd0, 16'd0, 1'b0);
        for (int k = 1; k <= 18; k++) sb.push_back('{cnt: (k >= 15) ? 2'd0 : 2'((k / 5) % 3), wrap: (k == 15)});
        for (int k = 1; sb.size() > 0; k++) begin
            cyc();
            e = sb.pop_front();
            n_checks++; if (count_out !== e.cnt || wrap_pulse !== e.wrap) begin
                n_fail++; $display("FAIL oneshot_seq k=%0d cnt=%0d wrap=%b exp cnt=%0d wrap=%b", k, count_out, wrap_pulse, e.cnt, e.wrap);
            end
            n_checks++; if (busy !== (k < 15)) begin
                n_fail++; $display("FAIL oneshot_busy k=%0d got=%b exp=%b", k, busy, (k < 15));
            end
        end
        n_checks++; if (wrap_count !== 8'd1) begin n_fail++; $display("FAIL oneshot_wcnt got=%0d exp=1", wrap_count); end
    endtask

    task automatic test_step();
        exp_t e;
        send(OP_LOAD, 2'd3, 16'd2, 1'b0);
        for (int s = 1; s <= 4; s++) begin
            sb.push_back('{cnt: 2'(s % 4), wrap: (s == 4)});
            send(OP_STEP, 2'd0, 16'd0, 1'b0);
            for (int c = 0; c < 3; c++) begin
                n_checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin
                    n_fail++; $display("FAIL step_ready s=%0d c=%0d ready=%b busy=%b exp ready=0 busy=1", s, c, cmd_ready, busy);
                end
                cyc();
            end
            e = sb.pop_front();
            n_checks++; if (count_out !== e.cnt || wrap_pulse !== e.wrap) begin
                n_fail++; $display("FAIL step_result s=%0d cnt=%0d wrap=%b exp cnt=%0d wrap=%b", s, count_out, wrap_pulse, e.cnt, e.wrap);
            end
            n_checks++; if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
                n_fail++; $display("FAIL step_done s=%0d ready=%b busy=%b exp ready=1 busy=0", s, cmd_ready, busy);
            end
        end
        cyc();
        n_checks++; if (wrap_pulse !== 1'b0 || wrap_count !== 8'd1) begin
            n_fail++; $display("FAIL step_after wrap=%b wcnt=%0d exp wrap=0 wcnt=1", wrap_pulse, wrap_count);
        end
    endtask

    task automatic test_stop_resume();
        exp_t e;
        send(OP_LOAD, 2'd3, 16'd0, 1'b0);
        send(OP_START, 2'd0, 16'd0, 1'b0);
        cyc();
        cyc();
        n_checks++; if (count_out !== 2'd2) begin n_fail++; $display("FAIL stop_pre got=%0d exp=2", count_out); end
        send(OP_STOP, 2'd0, 16'd0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            n_checks++; if (count_out !== 2'd2 || busy !== 1'b0) begin
                n_fail++; $display("FAIL stop_hold i=%0d cnt=%0d busy=%b exp cnt=2 busy=0", i, count_out, busy);
            end
            cyc();
        end
        send(OP_START, 2'd0, 16'd0, 1'b0);
        sb.push_back('{cnt: 2'd3, wrap: 1'b0});
        sb.push_back('{cnt: 2'd0, wrap: 1'b1});
        while (sb.size() > 0) begin
            cyc();
            e = sb.pop_front();
            n_checks++; if (count_out !== e.cnt || wrap_pulse !== e.wrap) begin
                n_fail++; $display("FAIL resume cnt=%0d wrap=%b exp cnt=%0d wrap=%b", count_out, wrap_pulse, e.cnt, e.wrap);
            end
        end
        send(OP_STOP, 2'd0, 16'd0, 1'b0);
    endtask

    task automatic test_limit_zero();
        exp_t e;
        int   exp_wc;
        send(OP_LOAD, 2'd0, 16'd0, 1'b0);
        send(OP_START, 2'd0, 16'd0, 1'b0);
        for (int k = 1; k <= 300; k++) sb.push_back('{cnt: 2'd0, wrap: 1'b1});
        for (int k = 1; sb.size() > 0; k++) begin
            cyc();
            e = sb.pop_front();
            exp_wc = (k > 255) ? 255 : k;
            n_checks++; if (count_out !== e.cnt || wrap_pulse !== e.wrap || wrap_count !== 8'(exp_wc)) begin
                n_fail++; $display("FAIL limit0 k=%0d cnt=%0d wrap=%b wcnt=%0d exp cnt=%0d wrap=%b wcnt=%0d",
                                   k, count_out, wrap_pulse, wrap_count, e.cnt, e.wrap, exp_wc);
            end
        end
        send(OP_STOP, 2'd0, 16'd0, 1'b0);
        n_checks++; if (wrap_count !== 8'd255 || busy !== 1'b0) begin
            n_fail++; $display("FAIL limit0_end wcnt=%0d busy=%b exp wcnt=255 busy=0", wrap_count, busy);
        end
    endtask

    task automatic test_reset_during_run();
        send(OP_LOAD, 2'd3, 16'd0, 1'b0);
        send(OP_START, 2'd0, 16'd0, 1'b0);
        for (int i = 0; i < 5; i++) cyc();
        n_checks++; if (wrap_count !== 8'd1 || count_out !== 2'd1) begin
            n_fail++; $display("FAIL rst_pre wcnt=%0d cnt=%0d exp wcnt=1 cnt=1", wrap_count, count_out);
        end
        rst = 1'b1;
        send(OP_START, 2'd0, 16'd0, 1'b0);
        rst = 1'b0;
        n_checks++; if (busy !== 1'b0 || count_out !== 2'd0 || io_oeb !== 2'b11 ||
                        wrap_count !== 8'd0 || wrap_pulse !== 1'b0) begin
            n_fail++; $display("FAIL rst_run busy=%b cnt=%0d oeb=%b wcnt=%0d wrap=%b exp 0 0 11 0 0",
                               busy, count_out, io_oeb, wrap_count, wrap_pulse);
        end
        cyc();
        n_checks++; if (busy !== 1'b0 || count_out !== 2'd0) begin
            n_fail++; $display("FAIL rst_after busy=%b cnt=%0d exp busy=0 cnt=0", busy, count_out);
        end
    endtask

    initial begin
        test_reset();
        test_invalid_cmd();
        test_run_basic();
        test_oneshot();
        test_step();
        test_stop_resume();
        test_limit_zero();
        test_reset_during_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
